mem_arbiter_2p: RTL and testbench

Two-port round-robin arbiter and sequencer for the 8x8 register-file memory (8-bit data, 3-bit address, chip_select/read_en/write_en). Two independent requesters each issue single read or write transactions through a req/gnt handshake. The block serialises the transactions onto the memory's single port and returns read data to the originating port. It sits between the requester logic and the memory, and is the only driver of the memory's control inputs.

---
 rtl/mem_arbiter_2p_if.sv | 49 ++++
 rtl/mem_arbiter_2p.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter_2p.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_2p_if.sv
// Bundle of the two requester handshakes and the single memory port for mem_arbiter_2p.
// With MEMARB_P1_WLOCK_EN defined the bundle also carries the port-1 write-error pulse.
interface mem_arbiter_2p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
`ifdef MEMARB_P1_WLOCK_EN
    logic              werr1;
`endif
    logic              mem_cs;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Requesters and the memory together form the "master" side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
`ifdef MEMARB_P1_WLOCK_EN
        input  werr1,
`endif
        input  mem_cs, mem_re, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
`ifdef MEMARB_P1_WLOCK_EN
        output werr1,
`endif
        output mem_cs, mem_re, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter/sequencer for an 8x8 register-file memory with registered read.
// Optional MEMARB_P1_WLOCK_EN: port 1 becomes read-only; its writes are granted, suppressed, and flagged on werr1.
module mem_arbiter_2p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic              clock,
    input logic              reset,
    mem_arbiter_2p_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    state_t state, state_nxt;
    port_t  last_winner, last_winner_nxt;
    port_t  owner, owner_nxt;

    logic              gnt0_q, gnt0_nxt;
    logic              gnt1_q, gnt1_nxt;
    logic              rvalid0_q, rvalid0_nxt;
    logic              rvalid1_q, rvalid1_nxt;
    logic [DATA_W-1:0] rdata0_q, rdata0_nxt;
    logic [DATA_W-1:0] rdata1_q, rdata1_nxt;
    logic              mem_cs_q, mem_cs_nxt;
    logic              mem_re_q, mem_re_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_W-1:0] mem_din_q, mem_din_nxt;
`ifdef MEMARB_P1_WLOCK_EN
    logic              werr1_q, werr1_nxt;
`endif

    // Winner selection for the current IDLE cycle: a tie goes to the port that did not win last.
    logic              any_req;
    port_t             pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              write_locked;

    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = (last_winner == PORT0) ? PORT1 : PORT0;
        end else begin
            pick = bus.req1 ? PORT1 : PORT0;
        end
        sel_we    = (pick == PORT1) ? bus.we1    : bus.we0;
        sel_addr  = (pick == PORT1) ? bus.addr1  : bus.addr0;
        sel_wdata = (pick == PORT1) ? bus.wdata1 : bus.wdata0;
`ifdef MEMARB_P1_WLOCK_EN
        write_locked = (pick == PORT1) && sel_we;
`else
        write_locked = 1'b0;
`endif
    end

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves one unassigned, which would infer a latch.
        state_nxt       = state;
        last_winner_nxt = last_winner;
        owner_nxt       = owner;
        gnt0_nxt        = 1'b0;
        gnt1_nxt        = 1'b0;
        rvalid0_nxt     = 1'b0;
        rvalid1_nxt     = 1'b0;
        rdata0_nxt      = rdata0_q;
        rdata1_nxt      = rdata1_q;
        mem_cs_nxt      = 1'b0;
        mem_re_nxt      = 1'b0;
        mem_we_nxt      = 1'b0;
        mem_addr_nxt    = '0;
        mem_din_nxt     = '0;
`ifdef MEMARB_P1_WLOCK_EN
        werr1_nxt       = 1'b0;
`endif

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    gnt0_nxt        = (pick == PORT0);
                    gnt1_nxt        = (pick == PORT1);
                    last_winner_nxt = pick;
                    owner_nxt       = pick;
                    mem_addr_nxt    = sel_addr;
                    mem_din_nxt     = sel_wdata;
                    mem_re_nxt      = !sel_we;
                    mem_we_nxt      = sel_we && !write_locked;
                    mem_cs_nxt      = !write_locked;
`ifdef MEMARB_P1_WLOCK_EN
                    werr1_nxt       = write_locked;
`endif
                    state_nxt       = ACCESS;
                end
            end

            // The memory acts at the edge leaving ACCESS; the defaults clear every mem_* output here.
            // A suppressed port-1 write also has mem_re low, so it returns straight to IDLE.
            ACCESS: begin
                state_nxt = mem_re_q ? CAPTURE : IDLE;
            end

            CAPTURE: begin
                if (owner == PORT0) begin
                    rdata0_nxt  = bus.mem_dout;
                    rvalid0_nxt = 1'b1;
                end else begin
                    rdata1_nxt  = bus.mem_dout;
                    rvalid1_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= PORT1;
            owner       <= PORT0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_cs_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
`ifdef MEMARB_P1_WLOCK_EN
            werr1_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            owner       <= owner_nxt;
            gnt0_q      <= gnt0_nxt;
            gnt1_q      <= gnt1_nxt;
            rvalid0_q   <= rvalid0_nxt;
            rvalid1_q   <= rvalid1_nxt;
            rdata0_q    <= rdata0_nxt;
            rdata1_q    <= rdata1_nxt;
            mem_cs_q    <= mem_cs_nxt;
            mem_re_q    <= mem_re_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_din_q   <= mem_din_nxt;
`ifdef MEMARB_P1_WLOCK_EN
            werr1_q     <= werr1_nxt;
`endif
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_cs   = mem_cs_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
`ifdef MEMARB_P1_WLOCK_EN
    assign bus.werr1    = werr1_q;
`endif

    // Memory-port invariants: one operation at a time, chip select exactly when an operation runs.
    a_no_rw_overlap: assert property (@(posedge clock) disable iff (reset) !(mem_re_q && mem_we_q));
    a_cs_matches_op: assert property (@(posedge clock) disable iff (reset) mem_cs_q == (mem_re_q || mem_we_q));
    a_single_grant:  assert property (@(posedge clock) disable iff (reset) !(gnt0_q && gnt1_q));

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Scoreboard bench for mem_arbiter_2p: behavioural 8x8 registered-read memory, per-port read queues.
// Also builds with MEMARB_P1_WLOCK_EN defined to cover the port-1 write lock.
module tb_mem_arbiter_2p;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mem_arbiter_2p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_arbiter_2p #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Behavioural memory: write and registered read both at the rising edge; contents survive arbiter reset.
    logic [DW-1:0] mem_array [8];
    initial begin
        for (int i = 0; i < 8; i++) mem_array[i] = '0;
        bus.mem_dout = '0;
    end
    always @(posedge clock) begin
        if (bus.mem_cs && bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_cs && bus.mem_re) bus.mem_dout <= mem_array[bus.mem_addr];
    end

    // Reference contents as the bench intends them, and expected read data per port.
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    logic [DW-1:0] fill_data [8] = '{8'hAA, 8'hB3, 8'h1E, 8'h82, 8'hC4, 8'hF3, 8'h68, 8'h44};

    initial for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // Scoreboard pop: every rvalid pulse must match the oldest outstanding read of that port.
    always @(negedge clock) begin
        logic [DW-1:0] exp_v;
        if (bus.rvalid0) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL rvalid0_unexpected: rdata0=%h with no read outstanding", bus.rdata0);
            end else begin
                exp_v = exp_q0.pop_front();
                if (bus.rdata0 !== exp_v) begin
                    errors++;
                    $display("FAIL rdata0: got %h expected %h", bus.rdata0, exp_v);
                end
            end
        end
        if (bus.rvalid1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL rvalid1_unexpected: rdata1=%h with no read outstanding", bus.rdata1);
            end else begin
                exp_v = exp_q1.pop_front();
                if (bus.rdata1 !== exp_v) begin
                    errors++;
                    $display("FAIL rdata1: got %h expected %h", bus.rdata1, exp_v);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One transaction on port p; returns the cycle of its grant (-1 on timeout).
    task automatic issue(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit track, output int gcyc);
        bit   got;
        logic locked;
        logic own_gnt, other_gnt;
        locked = 1'b0;
`ifdef MEMARB_P1_WLOCK_EN
        locked = (p == 1) && we;
`endif
        @(negedge clock);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            #1;
            got = (p == 0) ? bus.gnt0 : bus.gnt1;
        end
        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;

        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt%0d_timeout: no grant within 20 cycles, expected one", p);
            gcyc = -1;
            return;
        end
        gcyc = cyc;
        own_gnt   = (p == 0) ? bus.gnt0 : bus.gnt1;
        other_gnt = (p == 0) ? bus.gnt1 : bus.gnt0;

        checks++;
        if ({own_gnt, other_gnt, bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr} !==
            {1'b1, 1'b0, !locked, !we, we && !locked, addr}) begin
            errors++;
            $display("FAIL access_p%0d: gnt/other/cs/re/we/addr=%b%b%b%b%b %0d expected %b%b%b%b%b %0d",
                     p, own_gnt, other_gnt, bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr,
                     1'b1, 1'b0, !locked, !we, we && !locked, addr);
        end
        if (we && !locked) begin
            checks++;
            if (bus.mem_din !== wdata) begin
                errors++;
                $display("FAIL mem_din_p%0d: got %h expected %h", p, bus.mem_din, wdata);
            end
        end
`ifdef MEMARB_P1_WLOCK_EN
        checks++;
        if (bus.werr1 !== locked) begin
            errors++;
            $display("FAIL werr1_p%0d: got %b expected %b", p, bus.werr1, locked);
        end
`endif
        if (we && !locked) ref_mem[addr] = wdata;
        if (!we && track) begin
            if (p == 0) exp_q0.push_back(ref_mem[addr]);
            else        exp_q1.push_back(ref_mem[addr]);
        end

        @(posedge clock);
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_re, bus.mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL access_end_p%0d: gnt0/gnt1/cs/re/we=%b%b%b%b%b expected 00000",
                     p, bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_re, bus.mem_we);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
             bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b rdata=%h/%h cs/re/we=%b%b%b addr=%0d din=%h expected all 0",
                     bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                     bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
`ifdef MEMARB_P1_WLOCK_EN
        checks++;
        if (bus.werr1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_werr1: got %b expected 0", bus.werr1);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int g;
        issue(0, 1'b1, 3'd0, 8'hAA, 1'b1, g);
        issue(0, 1'b0, 3'd0, 8'h00, 1'b1, g);
        repeat (3) @(posedge clock);
    endtask

    task automatic test_fill_and_read();
        int g, prev;
        prev = -1;
        for (int a = 1; a < 8; a++) begin
            issue(0, 1'b1, AW'(a), fill_data[a], 1'b1, g);
            if (prev != -1) begin
                checks++;
                if (g - prev !== 2) begin
                    errors++;
                    $display("FAIL write_spacing: %0d cycles between grants, expected 2", g - prev);
                end
            end
            prev = g;
        end
        prev = -1;
        for (int a = 0; a < 8; a++) begin
            issue(1, 1'b0, AW'(a), 8'h00, 1'b1, g);
            if (prev != -1) begin
                checks++;
                if (g - prev !== 3) begin
                    errors++;
                    $display("FAIL read_spacing: %0d cycles between grants, expected 3", g - prev);
                end
            end
            prev = g;
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_tie();
        int g0, g1;
        apply_reset();
        fork
            issue(0, 1'b1, 3'd3, 8'h5D, 1'b1, g0);
            issue(1, 1'b0, 3'd3, 8'h00, 1'b1, g1);
        join
        checks++;
        if (g1 - g0 !== 2) begin
            errors++;
            $display("FAIL tie_order: gnt0 at %0d gnt1 at %0d, expected gnt0 first and gnt1 two cycles later", g0, g1);
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_alternation();
        int n;
        int port;
        @(negedge clock);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd5;
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(posedge clock);
            #1;
            if (bus.gnt0 || bus.gnt1) begin
                port = bus.gnt1 ? 1 : 0;
                checks++;
                if (port != n % 2) begin
                    errors++;
                    $display("FAIL alternation: grant %0d went to port %0d, expected port %0d", n, port, n % 2);
                end
                if (port == 0) exp_q0.push_back(ref_mem[1]);
                else           exp_q1.push_back(ref_mem[5]);
                n++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL alternation_timeout: %0d grants seen, expected 6", n);
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_reset_in_capture();
        int g;
        issue(1, 1'b0, 3'd4, 8'h00, 1'b0, g);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
             bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_capture: rvalid=%b%b rdata=%h/%h cs/re/we=%b%b%b addr=%0d din=%h expected all 0",
                     bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                     bus.mem_cs, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        reset = 1'b0;
        issue(1, 1'b0, 3'd4, 8'h00, 1'b1, g);
        repeat (3) @(posedge clock);
    endtask

    task automatic test_port1_write();
        int g;
`ifdef MEMARB_P1_WLOCK_EN
        issue(1, 1'b1, 3'd6, 8'hFF, 1'b1, g);
        issue(0, 1'b0, 3'd6, 8'h00, 1'b1, g);
`else
        issue(1, 1'b1, 3'd5, 8'h5A, 1'b1, g);
        issue(0, 1'b0, 3'd5, 8'h00, 1'b1, g);
`endif
        repeat (3) @(posedge clock);
    endtask

    task automatic test_drain();
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d reads still outstanding, expected 0/0",
                     exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;

        test_reset();
        test_write_read();
        test_fill_and_read();
        test_tie();
        test_alternation();
        test_reset_in_capture();
        test_port1_write();
        test_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
